// File: rtl/flexbex_imem_responder_if.sv
// rtl/flexbex_imem_responder_if.sv - instruction-fetch req/gnt/rvalid bus between prefetcher and memory
interface flexbex_imem_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  modport master (
    output instr_req_i,
    output instr_addr_i,
    input  instr_gnt_o,
    input  instr_rvalid_o,
    input  instr_rdata_o
  );

  modport slave (
    input  instr_req_i,
    input  instr_addr_i,
    output instr_gnt_o,
    output instr_rvalid_o,
    output instr_rdata_o
  );
endinterface

// File: rtl/flexbex_imem_responder.sv
// rtl/flexbex_imem_responder.sv - fixed-latency in-order instruction memory responder
// Grants fetches within an outstanding-credit budget, reads a 1-cycle SRAM and returns data after 2+WAIT_STATES cycles.
module flexbex_imem_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned WAIT_STATES     = 0,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] OOB_RDATA       = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  flexbex_imem_responder_if.slave        bus,
  input  logic                           mem_busy_i,
  output logic                           mem_en_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic [31:0]                    mem_rdata_i,
  output logic [2:0]                     outstanding_o,
  output logic                           err_o
);

  localparam int unsigned DEPTH        = 1 + WAIT_STATES;
  localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [2:0]  CREDIT_MAX   = 3'(MAX_OUTSTANDING);

  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_retire;
  logic [2:0]  w_out_net;
  logic        w_credit_ok;
  logic        w_gnt;

  logic        r_cap_valid;
  logic        r_cap_oob;
  logic        r_dl_valid [DEPTH];
  logic [31:0] r_dl_data  [DEPTH];
  logic [2:0]  r_outstanding;
  logic        r_err;

  assign w_offset    = bus.instr_addr_i - BASE_ADDR;
  assign w_in_range  = {1'b0, w_offset} < WINDOW_BYTES;
  assign w_retire    = r_dl_valid[DEPTH-1];
  assign w_out_net   = r_outstanding - {2'b00, w_retire};
  assign w_credit_ok = w_out_net < CREDIT_MAX;

  // Out-of-range fetches never touch the SRAM, so a busy port does not stall them.
  assign w_gnt = ~rst & bus.instr_req_i & (~mem_busy_i | ~w_in_range) & w_credit_ok;

  assign bus.instr_gnt_o    = w_gnt;
  assign bus.instr_rvalid_o = r_dl_valid[DEPTH-1];
  assign bus.instr_rdata_o  = r_dl_data[DEPTH-1];
  assign mem_en_o           = w_gnt & w_in_range;
  assign mem_addr_o         = w_offset[ADDR_WIDTH+1:2];
  assign outstanding_o      = r_outstanding;
  assign err_o              = r_err;

  // Stage data only advances with a valid entry, so the output word holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_valid <= 1'b0;
      r_cap_oob   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dl_valid[i] <= 1'b0;
        r_dl_data[i]  <= 32'h0000_0000;
      end
    end else begin
      r_cap_valid   <= w_gnt;
      r_cap_oob     <= ~w_in_range;
      r_dl_valid[0] <= r_cap_valid;
      if (r_cap_valid) begin
        r_dl_data[0] <= r_cap_oob ? OOB_RDATA : mem_rdata_i;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        if (r_dl_valid[i-1]) begin
          r_dl_data[i] <= r_dl_data[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 3'd0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + {2'b00, w_gnt} - {2'b00, w_retire};
      if (w_gnt & ~w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flexbex_imem_responder.sv
// tb/tb_flexbex_imem_responder.sv - directed self-checking bench for flexbex_imem_responder
module tb_flexbex_imem_responder;
  localparam logic [31:0] OOB = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flexbex_imem_responder_if if0 ();
  flexbex_imem_responder_if if3 ();

  logic        busy0, busy3, en0, en3, err0, err3;
  logic [9:0]  ma0, ma3;
  logic [31:0] rd0, rd3;
  logic [2:0]  out0, out3;

  flexbex_imem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0),
                           .MAX_OUTSTANDING(2), .OOB_RDATA(OOB)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .mem_busy_i(busy0), .mem_en_o(en0),
    .mem_addr_o(ma0), .mem_rdata_i(rd0), .outstanding_o(out0), .err_o(err0));

  flexbex_imem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3),
                           .MAX_OUTSTANDING(2), .OOB_RDATA(OOB)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .mem_busy_i(busy3), .mem_en_o(en3),
    .mem_addr_o(ma3), .mem_rdata_i(rd3), .outstanding_o(out3), .err_o(err3));

  function automatic logic [31:0] word_of(input logic [9:0] idx);
    if (idx == 10'd4) return 32'hDEAD_BEEF;
    return {16'hA5A5, 6'd0, idx};
  endfunction

  always @(posedge clk) begin
    if (en0) rd0 <= word_of(ma0);
    if (en3) rd3 <= word_of(ma3);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic t_single(input string tag);
    @(negedge clk); if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h0000_0010; #1;
    check({tag, "_gnt"},   32'(if0.instr_gnt_o), 32'd1);
    check({tag, "_men"},   32'(en0), 32'd1);
    check({tag, "_maddr"}, 32'(ma0), 32'd4);
    check({tag, "_rv0"},   32'(if0.instr_rvalid_o), 32'd0);
    @(negedge clk); if0.instr_req_i = 1'b0; #1;
    check({tag, "_out1"},  32'(out0), 32'd1);
    check({tag, "_rv1"},   32'(if0.instr_rvalid_o), 32'd0);
    @(negedge clk); #1;
    check({tag, "_rv2"},   32'(if0.instr_rvalid_o), 32'd1);
    check({tag, "_rd2"},   if0.instr_rdata_o, 32'hDEAD_BEEF);
    check({tag, "_out2"},  32'(out0), 32'd1);
    @(negedge clk); #1;
    check({tag, "_rv3"},   32'(if0.instr_rvalid_o), 32'd0);
    check({tag, "_out3"},  32'(out0), 32'd0);
    check({tag, "_hold"},  if0.instr_rdata_o, 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if0.instr_req_i = 1'b0; if3.instr_req_i = 1'b0;
      busy0 = 1'b0; busy3 = 1'b0;
    end
  endtask

  logic [11:0] exp_gnt3 = 12'b1100_0110_0011;  // bit c = cycle c
  logic [11:0] exp_rv3  = 12'b1100_0110_0000;

  initial begin
    int idx;
    int ret;
    if0.instr_req_i = 1'b0; if0.instr_addr_i = 32'h0;
    if3.instr_req_i = 1'b0; if3.instr_addr_i = 32'h0;
    busy0 = 1'b0; busy3 = 1'b0;

    #2;
    check("rst_gnt",  32'(if0.instr_gnt_o), 32'd0);
    check("rst_rv",   32'(if0.instr_rvalid_o), 32'd0);
    check("rst_rd",   if0.instr_rdata_o, 32'd0);
    check("rst_men",  32'(en0), 32'd0);
    check("rst_out",  32'(out0), 32'd0);
    check("rst_err",  32'(err0), 32'd0);
    check("rst_rv3",  32'(if3.instr_rvalid_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    t_single("t1");

    // Continuous fetch with no wait states: the same-cycle retire keeps the grant open every cycle.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'(idx * 4); #1;
      check($sformatf("t2_gnt%0d", c), 32'(if0.instr_gnt_o), 32'd1);
      check($sformatf("t2_out%0d", c), 32'(out0), 32'((c < 2) ? c : 2));
      check($sformatf("t2_rv%0d", c),  32'(if0.instr_rvalid_o), 32'(c >= 2));
      if (c >= 2) check($sformatf("t2_rd%0d", c), if0.instr_rdata_o, word_of(10'(c - 2)));
      if (if0.instr_gnt_o) idx++;
    end
    idle(3); #1;
    check("t2_drain", 32'(out0), 32'd0);

    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h20; busy0 = (c < 3); #1;
      check($sformatf("t4_gnt%0d", c), 32'(if0.instr_gnt_o), 32'(c == 3));
      check($sformatf("t4_men%0d", c), 32'(en0), 32'(c == 3));
      check($sformatf("t4_out%0d", c), 32'(out0), 32'd0);
    end
    @(negedge clk); if0.instr_req_i = 1'b0; busy0 = 1'b0; #1;
    check("t4_rv_early", 32'(if0.instr_rvalid_o), 32'd0);
    @(negedge clk); #1;
    check("t4_rv", 32'(if0.instr_rvalid_o), 32'd1);
    check("t4_rd", if0.instr_rdata_o, word_of(10'd8));

    @(negedge clk); if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h1000; busy0 = 1'b1; #1;
    check("t4o_gnt", 32'(if0.instr_gnt_o), 32'd1);
    check("t4o_men", 32'(en0), 32'd0);
    check("t4o_err0", 32'(err0), 32'd0);
    @(negedge clk); if0.instr_req_i = 1'b0; busy0 = 1'b0; #1;
    check("t4o_err1", 32'(err0), 32'd1);
    @(negedge clk); #1;
    check("t4o_rv", 32'(if0.instr_rvalid_o), 32'd1);
    check("t4o_rd", if0.instr_rdata_o, OOB);
    idle(2); #1;
    check("t4o_sticky", 32'(err0), 32'd1);

    // Two fetches in flight on the wait-state instance when reset hits.
    @(negedge clk); if3.instr_req_i = 1'b1; if3.instr_addr_i = 32'h40; #1;
    check("t6_gnt0", 32'(if3.instr_gnt_o), 32'd1);
    @(negedge clk); if3.instr_addr_i = 32'h44; #1;
    check("t6_gnt1", 32'(if3.instr_gnt_o), 32'd1);
    check("t6_out1", 32'(out3), 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    check("t6_rgnt", 32'(if3.instr_gnt_o), 32'd0);
    check("t6_rmen", 32'(en3), 32'd0);
    check("t6_rout", 32'(out3), 32'd0);
    check("t6_rerr", 32'(err0), 32'd0);
    check("t6_rrd0", if0.instr_rdata_o, 32'd0);
    check("t6_rrv3", 32'(if3.instr_rvalid_o), 32'd0);
    @(negedge clk); rst = 1'b0; if3.instr_req_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); #1;
      check($sformatf("t6_norv%0d", c), 32'(if3.instr_rvalid_o), 32'd0);
    end
    check("t6_out", 32'(out3), 32'd0);

    t_single("t1b");

    @(negedge clk); if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h0FFC; #1;
    check("t5_gnt0",  32'(if0.instr_gnt_o), 32'd1);
    check("t5_men0",  32'(en0), 32'd1);
    check("t5_maddr", 32'(ma0), 32'h3FF);
    @(negedge clk); if0.instr_addr_i = 32'h1000; #1;
    check("t5_gnt1", 32'(if0.instr_gnt_o), 32'd1);
    check("t5_men1", 32'(en0), 32'd0);
    check("t5_err0", 32'(err0), 32'd0);
    @(negedge clk); if0.instr_req_i = 1'b0; #1;
    check("t5_err1", 32'(err0), 32'd1);
    check("t5_rv0",  32'(if0.instr_rvalid_o), 32'd1);
    check("t5_rd0",  if0.instr_rdata_o, word_of(10'h3FF));
    @(negedge clk); #1;
    check("t5_rv1",  32'(if0.instr_rvalid_o), 32'd1);
    check("t5_rd1",  if0.instr_rdata_o, OOB);
    idle(2);

    // Wait-state instance: credit blocks cycles 2-4 and 7-9, grants resume on each retire.
    idx = 0;
    ret = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); if3.instr_req_i = 1'b1; if3.instr_addr_i = 32'h100 + 32'(idx * 4); #1;
      check($sformatf("t3_gnt%0d", c), 32'(if3.instr_gnt_o), 32'(exp_gnt3[c]));
      check($sformatf("t3_rv%0d", c),  32'(if3.instr_rvalid_o), 32'(exp_rv3[c]));
      check($sformatf("t3_out%0d", c), 32'(out3), 32'((c < 2) ? c : 2));
      if (exp_rv3[c]) begin
        check($sformatf("t3_rd%0d", c), if3.instr_rdata_o, word_of(10'(10'h40 + ret)));
        ret++;
      end
      if (if3.instr_gnt_o) idx++;
    end
    idle(8); #1;
    check("t3_drain", 32'(out3), 32'd0);
    check("t3_err",   32'(err3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
